// File: rtl/uart_pkg.sv
// Shared types and helpers for the shared UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    localparam int DATA_BITS = 8;

    // Clock cycles per serial bit (integer division, rounds down).
    function automatic int cycles_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: start bit, 8 data bits LSB first, stop bit.
//
// state | meaning
// IDLE  | line high, waiting for load
// START | line low for one bit time
// DATA  | shifting out bits 0..7 of the latched byte
// STOP  | line high for one bit time, done pulses in its last cycle
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 2500
) (
    input  logic       clk_25mhz,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(CYCLES_PER_BIT);

    uart_tx_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             tc;

    // Next-state logic; txd and busy are derived from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done    = 1'b0;
        tc      = (cnt_q == CNT_W'(CYCLES_PER_BIT - 1));
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    shreg_d = load_data;
                end
            end
            START: begin
                if (tc) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (tc) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 1'b1;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (tc) begin
                    cnt_d   = '0;
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == START) begin
            txd_d = 1'b0;
        end else if (state_d == DATA) begin
            txd_d = shreg_d[0];
        end else begin
            txd_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 transmit line among NUM_REQ producers.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLK_HZ  = 25_000_000,
    parameter int BAUD    = 10_000,
    parameter int NUM_REQ = 4
) (
    input  logic                       clk_25mhz,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       ftdi_txd,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] active_id
);

    localparam int CPB  = cycles_per_bit(CLK_HZ, BAUD);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] active_id_q, active_id_d;
    logic [ID_W-1:0] grant_idx;
    logic            grant_valid;
    logic            load;
    logic [7:0]      load_data;
    logic            ser_busy;
    logic            ser_done;
    int              idx;

    // Pick the first valid requester at or after rr_ptr; grant only while the line is idle.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
        load        = !rst && !ser_busy && grant_valid;
        req_ready   = load ? (NUM_REQ'(1) << grant_idx) : '0;
        load_data   = req_data[8*grant_idx +: 8];
        rr_ptr_d    = rr_ptr_q;
        active_id_d = active_id_q;
        if (load) begin
            active_id_d = grant_idx;
            rr_ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Arbiter pointer and current-owner registers.
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            active_id_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            active_id_q <= active_id_d;
        end
    end

    uart_tx_serializer #(
        .CYCLES_PER_BIT(CPB)
    ) u_ser (
        .clk_25mhz(clk_25mhz),
        .rst      (rst),
        .load     (load),
        .load_data(load_data),
        .txd      (ftdi_txd),
        .busy     (ser_busy),
        .done     (ser_done)
    );

    assign busy      = ser_busy;
    assign active_id = active_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a frame-level reference model.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic           clk_25mhz = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           ftdi_txd;
    logic           busy;
    logic [1:0]     active_id;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    uart_tx_arbiter #(.CLK_HZ(40), .BAUD(10), .NUM_REQ(N)) dut (
        .clk_25mhz(clk_25mhz),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .ftdi_txd (ftdi_txd),
        .busy     (busy),
        .active_id(active_id)
    );

    always #5 clk_25mhz = ~clk_25mhz;
    always @(posedge clk_25mhz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a frame is "on the line" for FRAME cycles after a grant;
    // the bit shown at offset o (1-based) is bit (o-1)/CPB of {stop, byte, start}.
    logic       m_valid = 1'b0;
    bit         m_in = 1'b0;
    int         m_off = 0;
    logic [7:0] m_byte = '0;
    int         m_aid = 0;
    int         m_rr = 0;

    always @(negedge clk_25mhz) begin
        logic [N-1:0] e_rdy;
        logic         e_txd;
        logic         e_busy;
        int           g;
        int           b;
        e_rdy = '0;
        g = -1;
        if (!m_in && !rst) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        if (g >= 0) e_rdy[g] = 1'b1;
        if (m_in) begin
            b = (m_off - 1) / CPB;
            e_busy = 1'b1;
            if (b == 0) e_txd = 1'b0;
            else if (b <= 8) e_txd = m_byte[b-1];
            else e_txd = 1'b1;
        end else begin
            e_busy = 1'b0;
            e_txd = 1'b1;
        end
        if (m_valid) begin
            check("txd", 32'(ftdi_txd), 32'(e_txd));
            check("busy", 32'(busy), 32'(e_busy));
            check("active_id", 32'(active_id), 32'(m_aid));
            check("req_ready", 32'(req_ready), 32'(e_rdy));
        end
        if (rst) begin
            m_in = 1'b0;
            m_off = 0;
            m_aid = 0;
            m_rr = 0;
            m_valid = 1'b1;
        end else if (m_in) begin
            m_off++;
            if (m_off > FRAME) m_in = 1'b0;
        end else if (g >= 0) begin
            m_in = 1'b1;
            m_off = 1;
            m_byte = req_data[8*g +: 8];
            m_aid = g;
            m_rr = (g + 1) % N;
        end
    end

    task automatic do_reset();
        @(posedge clk_25mhz); #1;
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk_25mhz);
        #1 rst = 1'b0;
    endtask

    // Called at posedge+1 with inputs set; returns at posedge+2 of the grant cycle.
    task automatic wait_grant(output int g, output int at);
        g = -1;
        at = -1;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (req_ready != '0) begin
                check("grant_onehot", 32'($onehot(req_ready)), 32'd1);
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                at = cyc;
                return;
            end
            @(posedge clk_25mhz); #1;
        end
        check("grant_timeout", 32'd0, 32'd1);
    endtask

    // Samples one frame from the grant cycle; ends at posedge+1 of the following idle cycle.
    task automatic capture(output logic [9:0] bits, output int nbusy,
                           input logic [N-1:0] valid_after, input logic [N*8-1:0] data_after,
                           input int pulse_k, input logic [N-1:0] pulse_mask);
        bits = '0;
        nbusy = 0;
        @(posedge clk_25mhz); #1;
        req_valid = valid_after;
        req_data = data_after;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk_25mhz);
            if ((k - 1) % CPB == 1) bits[(k-1)/CPB] = ftdi_txd;
            if (busy) nbusy++;
            if (k == pulse_k) begin
                #2 req_valid = valid_after | pulse_mask;
            end else if (k == pulse_k + 1) begin
                #2 req_valid = valid_after;
            end
        end
        @(posedge clk_25mhz); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, at, prev_at;
        logic [9:0] bits;
        int nb;
        int order[5];

        do_reset();

        // Single requester, 0x41.
        req_data[7:0] = 8'h41;
        req_valid = 4'b0001;
        wait_grant(g, at);
        check("single_ready", 32'(req_ready), 32'h1);
        capture(bits, nb, 4'b0000, req_data, 0, '0);
        check("single_bits", 32'(bits), 32'h282);
        check("single_busy_cycles", 32'(nb), 32'd40);

        // All four held valid: order 0,1,2,3,0 with 41-cycle period.
        do_reset();
        req_data = 32'h13121110;
        req_valid = 4'b1111;
        prev_at = 0;
        for (int f = 0; f < 5; f++) begin
            wait_grant(g, at);
            order[f] = g;
            if (f > 0) check("rr_period", 32'(at - prev_at), 32'd41);
            prev_at = at;
            capture(bits, nb, 4'b1111, req_data, 0, '0);
            check("rr_bits", 32'(bits), {22'd0, 1'b1, 8'h10 + 8'(f % 4), 1'b0});
        end
        check("rr_order0", 32'(order[0]), 32'd0);
        check("rr_order1", 32'(order[1]), 32'd1);
        check("rr_order2", 32'(order[2]), 32'd2);
        check("rr_order3", 32'(order[3]), 32'd3);
        check("rr_order4", 32'(order[4]), 32'd0);
        req_valid = '0;

        // rr_ptr at 2 with 1001 pending: 3 then 0.
        do_reset();
        req_data = 32'hC3B2A190;
        req_valid = 4'b0010;
        wait_grant(g, at);
        check("ptr_setup", 32'(g), 32'd1);
        capture(bits, nb, 4'b1001, req_data, 0, '0);
        wait_grant(g, at);
        check("ptr_first", 32'(g), 32'd3);
        capture(bits, nb, 4'b0001, req_data, 0, '0);
        check("ptr_first_bits", 32'(bits), {22'd0, 1'b1, 8'hC3, 1'b0});
        wait_grant(g, at);
        check("ptr_second", 32'(g), 32'd0);
        capture(bits, nb, 4'b0000, req_data, 0, '0);
        check("ptr_second_bits", 32'(bits), {22'd0, 1'b1, 8'h90, 1'b0});

        // Reset during DATA bit 3.
        req_data = 32'h005A00AA;
        req_valid = 4'b0100;
        wait_grant(g, at);
        check("rst_setup", 32'(g), 32'd2);
        @(posedge clk_25mhz); #1 req_valid = '0;
        repeat (17) @(posedge clk_25mhz);
        #1 rst = 1'b1;
        @(posedge clk_25mhz); #1 rst = 1'b0;
        check("rst_txd", 32'(ftdi_txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_active_id", 32'(active_id), 32'd0);
        req_valid = 4'b0101;
        wait_grant(g, at);
        check("rst_regrant", 32'(g), 32'd0);
        capture(bits, nb, 4'b0000, req_data, 0, '0);
        check("rst_regrant_bits", 32'(bits), {22'd0, 1'b1, 8'hAA, 1'b0});

        // One-cycle valid pulse mid-frame is ignored.
        req_data = 32'h003CA500;
        req_valid = 4'b0010;
        wait_grant(g, at);
        check("pulse_grant", 32'(g), 32'd1);
        capture(bits, nb, 4'b0000, req_data, 10, 4'b0100);
        check("pulse_bits", 32'(bits), {22'd0, 1'b1, 8'hA5, 1'b0});
        check("pulse_busy_cycles", 32'(nb), 32'd40);

        // 0xFF then 0x00 from requester 0, back to back.
        req_data = 32'h000000FF;
        req_valid = 4'b0001;
        wait_grant(g, at);
        prev_at = at;
        capture(bits, nb, 4'b0001, 32'h00000000, 0, '0);
        check("ff_bits", 32'(bits), {22'd0, 1'b1, 8'hFF, 1'b0});
        check("gap_txd", 32'(ftdi_txd), 32'd1);
        check("gap_busy", 32'(busy), 32'd0);
        wait_grant(g, at);
        check("zero_grant", 32'(g), 32'd0);
        check("zero_period", 32'(at - prev_at), 32'd41);
        capture(bits, nb, 4'b0000, req_data, 0, '0);
        check("zero_bits", 32'(bits), {22'd0, 1'b1, 8'h00, 1'b0});

        repeat (3) @(posedge clk_25mhz);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
